// File: rtl/sensor_debouncer.sv
// sensor_debouncer: synchronises and debounces the raw field-sensor lines.
// A prescaler produces the sample ticks. On each tick, every channel counts
// how many ticks in a row its synchronised level has differed from the
// clean level, and takes the new level when that count is reached.
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   raw_in       unsynchronised sensor levels (bit0 low_water .. bit5 low_temp)
//   clean_out    debounced, registered levels
//   changed      one-cycle pulse per channel, in the cycle clean_out updates
//   settled      sticky flag; all channels stable since reset
//   sample_tick  registered copy of the internal sample tick
module sensor_debouncer #(
    parameter int unsigned CHANNELS    = 6,
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] changed,
    output logic                settled,
    output logic                sample_tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned SW = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(DEBOUNCE);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick_int;

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] clean_q, clean_d;
    logic [CHANNELS-1:0] changed_q, changed_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic                settled_q, settled_d;
    logic                tick_q, tick_d;
    logic                all_idle;

    // Synchroniser shift chain; the last stage is the synchronised level.
    always_comb begin
        sync_d[0] = raw_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Prescaler: the tick fires on the last count, then the count wraps.
    always_comb begin
        tick_int = (presc_q == PRESC_LAST);
        presc_d  = tick_int ? '0 : presc_q + PW'(1);
        tick_d   = tick_int;
    end

    // Per-channel debounce counters; they only move on tick cycles.
    always_comb begin
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        changed_d = '0;
        all_idle  = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cnt_q[i] != '0) begin
                all_idle = 1'b0;
            end
            if (tick_int) begin
                if (synced[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i]   = synced[i];
                    cnt_d[i]     = '0;
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Settle tracking: wait at least DEBOUNCE ticks, then require a quiet tick.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        settled_d    = settled_q;
        if (tick_int) begin
            if (settle_cnt_q != SETTLE_MAX) begin
                settle_cnt_d = settle_cnt_q + SW'(1);
            end
            if ((settle_cnt_q == SETTLE_MAX) && all_idle && (synced == clean_q)) begin
                settled_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            presc_q      <= '0;
            clean_q      <= '0;
            changed_q    <= '0;
            settle_cnt_q <= '0;
            settled_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            presc_q      <= presc_d;
            clean_q      <= clean_d;
            changed_q    <= changed_d;
            settle_cnt_q <= settle_cnt_d;
            settled_q    <= settled_d;
            tick_q       <= tick_d;
        end
    end

    assign clean_out   = clean_q;
    assign changed     = changed_q;
    assign settled     = settled_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Bench for sensor_debouncer: directed vector table for the main
// configuration (PRESCALE=4, DEBOUNCE=3), hand-written sequences for the
// mid-operation reset and the PRESCALE=1/DEBOUNCE=1 instance.
module tb_sensor_debouncer;

    logic       clock;
    logic       reset_n;
    logic [5:0] raw_in;
    logic [5:0] clean_out;
    logic [5:0] changed;
    logic       settled;
    logic       sample_tick;

    logic [5:0] raw1;
    logic [5:0] clean1;
    logic [5:0] changed1;
    logic       settled1;
    logic       tick1;

    int checks   = 0;
    int failures = 0;

    sensor_debouncer #(
        .CHANNELS(6), .PRESCALE(4), .DEBOUNCE(3), .SYNC_STAGES(2)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .changed    (changed),
        .settled    (settled),
        .sample_tick(sample_tick)
    );

    sensor_debouncer #(
        .CHANNELS(6), .PRESCALE(1), .DEBOUNCE(1), .SYNC_STAGES(2)
    ) u_dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .raw_in     (raw1),
        .clean_out  (clean1),
        .changed    (changed1),
        .settled    (settled1),
        .sample_tick(tick1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] raw;
        int         adv;
        logic [5:0] clean;
        logic [5:0] chg;
        logic       settled;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] c, input logic [5:0] ch,
                             input logic s, input logic t);
        check({tag, ".clean"},   32'(clean_out),   32'(c));
        check({tag, ".changed"}, 32'(changed),     32'(ch));
        check({tag, ".settled"}, 32'(settled),     32'(s));
        check({tag, ".tick"},    32'(sample_tick), 32'(t));
    endtask

    function automatic vec_t mk(input logic [5:0] raw, input int adv, input logic [5:0] c,
                                input logic [5:0] ch, input logic s, input logic t);
        vec_t v;
        v.raw = raw; v.adv = adv; v.clean = c; v.chg = ch; v.settled = s; v.tick = t;
        return v;
    endfunction

    initial begin
        // Edge numbers in comments count posedges after reset release.
        // Power-up: ticks at edges 4, 8, 12; update on the 3rd, settled on the 4th.
        vecs.push_back(mk(6'h3F, 3, 6'h00, 6'h00, 1'b0, 1'b0)); // e3
        vecs.push_back(mk(6'h3F, 1, 6'h00, 6'h00, 1'b0, 1'b1)); // e4
        vecs.push_back(mk(6'h3F, 1, 6'h00, 6'h00, 1'b0, 1'b0)); // e5
        vecs.push_back(mk(6'h3F, 6, 6'h00, 6'h00, 1'b0, 1'b0)); // e11
        vecs.push_back(mk(6'h3F, 1, 6'h3F, 6'h3F, 1'b0, 1'b1)); // e12
        vecs.push_back(mk(6'h3F, 1, 6'h3F, 6'h00, 1'b0, 1'b0)); // e13
        vecs.push_back(mk(6'h3F, 2, 6'h3F, 6'h00, 1'b0, 1'b0)); // e15
        vecs.push_back(mk(6'h3F, 1, 6'h3F, 6'h00, 1'b1, 1'b1)); // e16
        // Glitch on bit0 lasting two ticks, then a one-tick glitch after recovery.
        vecs.push_back(mk(6'h3E, 4, 6'h3F, 6'h00, 1'b1, 1'b1)); // e20
        vecs.push_back(mk(6'h3E, 4, 6'h3F, 6'h00, 1'b1, 1'b1)); // e24
        vecs.push_back(mk(6'h3F, 4, 6'h3F, 6'h00, 1'b1, 1'b1)); // e28
        vecs.push_back(mk(6'h3F, 12, 6'h3F, 6'h00, 1'b1, 1'b1)); // e40
        vecs.push_back(mk(6'h3E, 4, 6'h3F, 6'h00, 1'b1, 1'b1)); // e44
        vecs.push_back(mk(6'h3F, 4, 6'h3F, 6'h00, 1'b1, 1'b1)); // e48
        // Bits 2 and 4 toggle together.
        vecs.push_back(mk(6'h2B, 11, 6'h3F, 6'h00, 1'b1, 1'b0)); // e59
        vecs.push_back(mk(6'h2B, 1, 6'h2B, 6'h14, 1'b1, 1'b1)); // e60
        vecs.push_back(mk(6'h2B, 1, 6'h2B, 6'h00, 1'b1, 1'b0)); // e61
        // Bit5 toggles, bit3 one tick later.
        vecs.push_back(mk(6'h0B, 4, 6'h2B, 6'h00, 1'b1, 1'b0)); // e65
        vecs.push_back(mk(6'h03, 6, 6'h2B, 6'h00, 1'b1, 1'b0)); // e71
        vecs.push_back(mk(6'h03, 1, 6'h0B, 6'h20, 1'b1, 1'b1)); // e72
        vecs.push_back(mk(6'h03, 1, 6'h0B, 6'h00, 1'b1, 1'b0)); // e73
        vecs.push_back(mk(6'h03, 2, 6'h0B, 6'h00, 1'b1, 1'b0)); // e75
        vecs.push_back(mk(6'h03, 1, 6'h03, 6'h08, 1'b1, 1'b1)); // e76
        vecs.push_back(mk(6'h03, 1, 6'h03, 6'h00, 1'b1, 1'b0)); // e77

        reset_n = 1'b0;
        raw_in  = 6'h3F;
        raw1    = 6'h00;
        repeat (3) @(posedge clock);
        #1;
        check_all("reset", 6'h00, 6'h00, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            raw_in = vecs[k].raw;
            repeat (vecs[k].adv) @(posedge clock);
            #1;
            check_all($sformatf("vec%0d", k), vecs[k].clean, vecs[k].chg,
                      vecs[k].settled, vecs[k].tick);
        end

        // Reset mid-count: bit1 has seen two mismatching ticks (e80, e84).
        raw_in = 6'h01;
        repeat (7) @(posedge clock);
        #1;
        check_all("pre_rst", 6'h03, 6'h00, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("in_rst", 6'h00, 6'h00, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        raw_in  = 6'h03;
        repeat (3) @(posedge clock);
        #1;
        check_all("rst_e3", 6'h00, 6'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_all("rst_e4", 6'h00, 6'h00, 1'b0, 1'b1);
        repeat (7) @(posedge clock);
        #1;
        check_all("rst_e11", 6'h00, 6'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_all("rst_e12", 6'h03, 6'h03, 1'b0, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        check_all("rst_e16", 6'h03, 6'h00, 1'b1, 1'b1);

        // Degenerate instance: tick every cycle, single-tick debounce.
        check("deg.pre_clean", 32'(clean1), 32'h0);
        check("deg.tick", 32'(tick1), 32'h1);
        raw1 = 6'h01;
        repeat (2) @(posedge clock);
        #1;
        check("deg.e2_clean", 32'(clean1), 32'h0);
        check("deg.e2_chg", 32'(changed1), 32'h0);
        @(posedge clock);
        #1;
        check("deg.e3_clean", 32'(clean1), 32'h01);
        check("deg.e3_chg", 32'(changed1), 32'h01);
        @(posedge clock);
        #1;
        check("deg.e4_clean", 32'(clean1), 32'h01);
        check("deg.e4_chg", 32'(changed1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
